// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//
// Writable byte-wide instruction memory filled from a little-endian byte
// stream. The loader writes from byte address 0 upward and holds the IF/ID
// stages frozen while a session is in progress. The read side serves 32-bit
// little-endian words to the fetch stage combinationally.
//
// Parameters:
//   DEPTH_BYTES  memory size in bytes (4..4096)
//   PTR_W        write pointer / byte count width, 2**PTR_W > DEPTH_BYTES
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   load_start   one-cycle session request, honoured only when idle
//   in_valid     stream byte valid
//   in_byte      stream byte
//   in_last      final byte of the session (qualified by in_valid)
//   in_ready     loader accepts a byte this cycle
//   freeze       IF/ID freeze, high while a session is active
//   load_done    one-cycle pulse at session end
//   load_err     status of the last session, held until the next session
//   byte_count   bytes accepted in the current or last session
//   fetch_addr   IF byte address (PC), need not be word aligned
//   fetch_instr  {mem[a+3], mem[a+2], mem[a+1], mem[a]}
//   checksum     XOR of accepted bytes
//
// Optional feature:
//   IMEM_CHECKSUM_EN  when defined, builds the running XOR checksum register;
//                     otherwise checksum is tied to zero.
// ---------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int DEPTH_BYTES = 188,
    parameter int PTR_W       = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    input  logic             in_last,
    output logic             in_ready,
    output logic             freeze,
    output logic             load_done,
    output logic             load_err,
    output logic [PTR_W-1:0] byte_count,
    input  logic [31:0]      fetch_addr,
    output logic [31:0]      fetch_instr,
    output logic [7:0]       checksum
);

    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [PTR_W-1:0] wrPtr;
    logic [7:0]       mem [DEPTH_BYTES];

    logic accept;
    logic sessionStart;
    logic atEnd;

    assign accept       = in_valid & in_ready;
    assign sessionStart = (state == IDLE) & load_start;
    assign atEnd        = (wrPtr == PTR_W'(DEPTH_BYTES - 1));

    // The write pointer and the session byte count always advance together
    // from the same cleared value, so one register serves both.
    assign byte_count = wrPtr;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and state-decoded outputs
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        freeze    = 1'b0;
        load_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_start) begin
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                freeze   = 1'b1;
                // End of session: explicit last byte, or the top byte of the
                // memory was just written (no wrap-around).
                if (accept && (in_last || atEnd)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                freeze    = 1'b1;
                load_done = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Write pointer and error status
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr    <= '0;
            load_err <= 1'b0;
        end else if (sessionStart) begin
            wrPtr    <= '0;
            load_err <= 1'b0;
        end else if (accept) begin
            wrPtr <= wrPtr + 1'b1;
            if (in_last) begin
                // The new count is a multiple of 4 exactly when the old
                // count ends in 2'b11.
                load_err <= (wrPtr[1:0] != 2'b11);
            end else if (atEnd) begin
                load_err <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Byte storage
    // -----------------------------------------------------------------------
    // NOTE: the storage is built from resettable flops rather than a RAM
    // macro because reset must return every byte to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (accept) begin
            mem[wrPtr[AW-1:0]] <= in_byte;
        end
    end

    // -----------------------------------------------------------------------
    // Combinational read port: four byte lanes, 32-bit address arithmetic,
    // anything at or beyond the depth reads as zero.
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < 4; k++) begin : gRead
        logic [31:0] laneAddr;
        assign laneAddr = fetch_addr + 32'(k);
        assign fetch_instr[8*k +: 8] = (laneAddr < 32'(DEPTH_BYTES))
                                       ? mem[laneAddr[AW-1:0]] : 8'h00;
    end

    // -----------------------------------------------------------------------
    // Optional running checksum
    // -----------------------------------------------------------------------
`ifdef IMEM_CHECKSUM_EN
    logic [7:0] csReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csReg <= 8'h00;
        end else if (sessionStart) begin
            csReg <= 8'h00;
        end else if (accept) begin
            csReg <= csReg ^ in_byte;
        end
    end

    assign checksum = csReg;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
//
// Drives two loader instances (default depth and depth 8) from one stimulus
// set, with a select steering session requests and valid to one of them.
// A session-level model (byte array, byte counter, status flags) predicts
// every output each cycle; directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

    localparam int DA = 188;
    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        loadStart;
    logic        inValid;
    logic [7:0]  inByte;
    logic        inLast;
    logic [31:0] fetchAddr;
    int          sel;

    logic        aReady, aFreeze, aDone, aErr;
    logic [11:0] aCount;
    logic [31:0] aInstr;
    logic [7:0]  aCs;
    logic        bReady, bFreeze, bDone, bErr;
    logic [11:0] bCount;
    logic [31:0] bInstr;
    logic [7:0]  bCs;

    always #5 clk = ~clk;

    instr_mem_loader #(.DEPTH_BYTES(DA), .PTR_W(12)) dutA (
        .clk(clk), .rst(rst),
        .load_start(loadStart & (sel == 0)), .in_valid(inValid & (sel == 0)),
        .in_byte(inByte), .in_last(inLast),
        .in_ready(aReady), .freeze(aFreeze), .load_done(aDone), .load_err(aErr),
        .byte_count(aCount), .fetch_addr(fetchAddr), .fetch_instr(aInstr),
        .checksum(aCs)
    );

    instr_mem_loader #(.DEPTH_BYTES(DB), .PTR_W(12)) dutB (
        .clk(clk), .rst(rst),
        .load_start(loadStart & (sel == 1)), .in_valid(inValid & (sel == 1)),
        .in_byte(inByte), .in_last(inLast),
        .in_ready(bReady), .freeze(bFreeze), .load_done(bDone), .load_err(bErr),
        .byte_count(bCount), .fetch_addr(fetchAddr), .fetch_instr(bInstr),
        .checksum(bCs)
    );

    // ------------------------------------------------------------------
    // Checking bookkeeping
    // ------------------------------------------------------------------
    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Session-level model: a session is either loading, in its one-cycle
    // completion, or absent. Bytes land at address = bytes so far.
    // ------------------------------------------------------------------
    logic [7:0] mMem [2][DA];
    bit         mLoading [2];
    bit         mEnding  [2];
    int         mCnt     [2];
    bit         mErr     [2];
    logic [7:0] mCs      [2];

    function automatic int depthOf(input int i);
        return (i == 1) ? DB : DA;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < DA; j++) mMem[i][j] = 8'h00;
            mLoading[i] = 1'b0;
            mEnding[i]  = 1'b0;
            mCnt[i]     = 0;
            mErr[i]     = 1'b0;
            mCs[i]      = 8'h00;
        end
    endtask

    task automatic modelStep(input int i, input bit st, input bit vl);
        if (mEnding[i]) begin
            mEnding[i] = 1'b0;
        end else if (!mLoading[i]) begin
            if (st) begin
                mLoading[i] = 1'b1;
                mCnt[i]     = 0;
                mErr[i]     = 1'b0;
                mCs[i]      = 8'h00;
            end
        end else if (vl) begin
            mMem[i][mCnt[i]] = inByte;
            mCnt[i]++;
            mCs[i] ^= inByte;
            if (inLast) begin
                mLoading[i] = 1'b0;
                mEnding[i]  = 1'b1;
                mErr[i]     = (mCnt[i] % 4) != 0;
            end else if (mCnt[i] == depthOf(i)) begin
                mLoading[i] = 1'b0;
                mEnding[i]  = 1'b1;
                mErr[i]     = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] expFetch(input int i, input logic [31:0] addr);
        logic [31:0] r;
        logic [31:0] ak;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            ak = addr + 32'(k);
            if (ak < 32'(depthOf(i))) r[8*k +: 8] = mMem[i][ak];
        end
        return r;
    endfunction

    function automatic logic [7:0] expCs(input int i);
`ifdef IMEM_CHECKSUM_EN
        return mCs[i];
`else
        return 8'h00 & mCs[i];
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                modelStep(i, loadStart && (sel == i), inValid && (sel == i));
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst) begin
            check("a_ready",  {31'b0, aReady},  {31'b0, mLoading[0]});
            check("a_freeze", {31'b0, aFreeze}, {31'b0, mLoading[0] | mEnding[0]});
            check("a_done",   {31'b0, aDone},   {31'b0, mEnding[0]});
            check("a_err",    {31'b0, aErr},    {31'b0, mErr[0]});
            check("a_count",  {20'b0, aCount},  32'(mCnt[0]));
            check("a_fetch",  aInstr,           expFetch(0, fetchAddr));
            check("a_cs",     {24'b0, aCs},     {24'b0, expCs(0)});
            check("b_ready",  {31'b0, bReady},  {31'b0, mLoading[1]});
            check("b_freeze", {31'b0, bFreeze}, {31'b0, mLoading[1] | mEnding[1]});
            check("b_done",   {31'b0, bDone},   {31'b0, mEnding[1]});
            check("b_err",    {31'b0, bErr},    {31'b0, mErr[1]});
            check("b_count",  {20'b0, bCount},  32'(mCnt[1]));
            check("b_fetch",  bInstr,           expFetch(1, fetchAddr));
            check("b_cs",     {24'b0, bCs},     {24'b0, expCs(1)});
        end
    end

    // Event counters for pulse/duration checks (tests use differences).
    int doneCntA = 0, doneCntB = 0, freezeCycA = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (aDone)   doneCntA++;
            if (bDone)   doneCntB++;
            if (aFreeze) freezeCycA++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic startLoad(input int s);
        sel       = s;
        loadStart = 1'b1;
        cyc();
        loadStart = 1'b0;
    endtask

    task automatic sendBytes(input logic [7:0] bytes[$], input bit last,
                             input bit throttle);
        for (int n = 0; n < bytes.size(); n++) begin
            inValid = 1'b1;
            inByte  = bytes[n];
            inLast  = last && (n == bytes.size() - 1);
            cyc();
            if (throttle) begin
                inValid = 1'b0;
                inLast  = 1'b0;
                cyc();
            end
        end
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int d0, f0;
        logic [7:0] q[$];

        rst = 1'b0; loadStart = 1'b0; inValid = 1'b0; inByte = 8'h00;
        inLast = 1'b0; fetchAddr = 32'h0; sel = 0;
        modelReset();
        #3;
        check("rst_ready",  {31'b0, aReady},  32'h0);
        check("rst_freeze", {31'b0, aFreeze}, 32'h0);
        check("rst_done",   {31'b0, aDone},   32'h0);
        check("rst_err",    {31'b0, aErr},    32'h0);
        check("rst_count",  {20'b0, aCount},  32'h0);
        check("rst_cs",     {24'b0, aCs},     32'h0);
        check("rst_fetch",  aInstr,           32'h0);
        check("rst_fetch_b", bInstr,          32'h0);
        #9 rst = 1'b1;
        cyc();

        // Basic load with one idle LOAD cycle before the stream.
        d0 = doneCntA; f0 = freezeCycA;
        startLoad(0);
        cyc();
        q = '{8'h14, 8'h00, 8'hA0, 8'hE3};
        sendBytes(q, 1'b1, 1'b0);
        cyc(); cyc();
        fetchAddr = 32'd0;
        @(negedge clk);
        check("basic_fetch0",  aInstr, 32'hE3A00014);
        check("basic_count",   {20'b0, aCount}, 32'd4);
        check("basic_err",     {31'b0, aErr}, 32'd0);
        check("basic_done1",   32'(doneCntA - d0), 32'd1);
        check("basic_freeze6", 32'(freezeCycA - f0), 32'd6);
`ifdef IMEM_CHECKSUM_EN
        check("basic_cs", {24'b0, aCs}, 32'h57);
`else
        check("basic_cs", {24'b0, aCs}, 32'h00);
`endif
        fetchAddr = 32'd1;
        @(negedge clk);
        check("basic_unaligned", aInstr, 32'h00E3A000);
        cyc();

        // Throttled stream: valid low on alternate cycles.
        startLoad(0);
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        sendBytes(q, 1'b1, 1'b1);
        cyc();
        fetchAddr = 32'd4;
        @(negedge clk);
        check("thr_fetch4", aInstr, 32'h88776655);
        check("thr_count",  {20'b0, aCount}, 32'd8);
        check("thr_err",    {31'b0, aErr}, 32'd0);
        fetchAddr = 32'd0;
        @(negedge clk);
        check("thr_fetch0", aInstr, 32'h44332211);
        cyc();

        // Reset in the middle of a session.
        d0 = doneCntA;
        startLoad(0);
        q = '{8'hDE, 8'hAD};
        sendBytes(q, 1'b0, 1'b0);
        rst = 1'b0;
        modelReset();
        #1;
        check("rmid_freeze", {31'b0, aFreeze}, 32'd0);
        check("rmid_ready",  {31'b0, aReady}, 32'd0);
        check("rmid_fetch0", aInstr, 32'h0);
        check("rmid_count",  {20'b0, aCount}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        cyc(); cyc(); cyc();
        check("rmid_nodone", 32'(doneCntA - d0), 32'd0);

        // Partial word after reset.
        startLoad(0);
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
        sendBytes(q, 1'b1, 1'b0);
        cyc();
        fetchAddr = 32'd4;
        @(negedge clk);
        check("part_fetch4", aInstr, 32'h000000AA);
        check("part_err",    {31'b0, aErr}, 32'd1);
        check("part_count",  {20'b0, aCount}, 32'd5);
        fetchAddr = 32'd0;
        @(negedge clk);
        check("part_fetch0", aInstr, 32'h04030201);
        cyc();

        // Overflow on the depth-8 instance: 9 bytes, no last marker.
        d0 = doneCntB;
        startLoad(1);
        for (int n = 0; n < 9; n++) begin
            inValid = 1'b1;
            inByte  = 8'hA0 + 8'(n);
            inLast  = 1'b0;
            if (n == 8) begin
                @(negedge clk);
                check("ovf_ready9", {31'b0, bReady}, 32'd0);
            end
            cyc();
        end
        inValid = 1'b0;
        cyc();
        fetchAddr = 32'd6;
        @(negedge clk);
        check("ovf_fetch6", bInstr, 32'h0000A7A6);
        check("ovf_count",  {20'b0, bCount}, 32'd8);
        check("ovf_err",    {31'b0, bErr}, 32'd1);
        check("ovf_done1",  32'(doneCntB - d0), 32'd1);
        fetchAddr = 32'd7;
        @(negedge clk);
        check("ovf_fetch7", bInstr, 32'h000000A7);
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
